// File: rtl/systolic_array_nxn_if.sv
// Job control, operand-beat and result-stream bundle for systolic_array_nxn.
interface systolic_array_nxn_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 40,
  parameter int unsigned KW = 8
);
  localparam int unsigned RW = $clog2(N);

  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_data;
  logic [RW-1:0]   out_row;
  logic [RW-1:0]   out_col;
  logic            busy;
  logic            done;

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, busy, done
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// NxN output-stationary systolic multiplier C = A(NxK) * B(KxN) with internal
// input skew, valid/ready operand beats and a row-major result stream.
module systolic_array_nxn #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 40,
  parameter int unsigned KW = 8
) (
  input logic                clk,
  input logic                rst,
  systolic_array_nxn_if.slave bus
);
  localparam int unsigned RW  = $clog2(N);
  localparam int unsigned DCW = $clog2(2 * N);
  localparam int unsigned PW  = 2 * DW;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   beats, beats_nxt;
  logic [DCW-1:0]  dcnt, dcnt_nxt;
  logic [RW-1:0]   row_nxt, col_nxt;
  logic [AW-1:0]   data_nxt;
  logic            done_nxt;
  logic            clear;
  logic            adv;
  logic            load_st;

  logic signed [DW-1:0] a_edge [N];
  logic signed [DW-1:0] b_edge [N];
  logic signed [DW-1:0] a_h    [N][N-1];
  logic signed [DW-1:0] b_v    [N-1][N];
  logic signed [AW-1:0] acc    [N][N];

  assign load_st = (state == LOAD);

  // Row i of A and column i of B are delayed i steps; drain injects zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DW-1:0] a_src, b_src;
    assign a_src = load_st ? bus.a_col[i*DW +: DW] : '0;
    assign b_src = load_st ? bus.b_row[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_src;
      assign b_edge[i] = b_src;
    end else begin : g_delay
      logic signed [DW-1:0] a_d [i];
      logic signed [DW-1:0] b_d [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < i; d++) begin
            a_d[d] <= '0;
            b_d[d] <= '0;
          end
        end else if (clear) begin
          for (int d = 0; d < i; d++) begin
            a_d[d] <= '0;
            b_d[d] <= '0;
          end
        end else if (adv) begin
          a_d[0] <= a_src;
          b_d[0] <= b_src;
          for (int d = 1; d < i; d++) begin
            a_d[d] <= a_d[d-1];
            b_d[d] <= b_d[d-1];
          end
        end
      end
      assign a_edge[i] = a_d[i-1];
      assign b_edge[i] = b_d[i-1];
    end
  end

  // Processing elements: a moves east, b moves south, acc wraps modulo 2^AW.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [DW-1:0] a_in, b_in;
      logic signed [PW-1:0] prod;
      logic signed [AW-1:0] acc_q;

      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_west
        assign a_in = a_h[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_north
        assign b_in = b_v[i-1][j];
      end

      assign prod = PW'(a_in) * PW'(b_in);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       acc_q <= '0;
        else if (clear) acc_q <= '0;
        else if (adv)   acc_q <= acc_q + AW'(prod);
      end
      assign acc[i][j] = acc_q;

      if (j < N - 1) begin : g_east
        logic signed [DW-1:0] a_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)       a_q <= '0;
          else if (clear) a_q <= '0;
          else if (adv)   a_q <= a_in;
        end
        assign a_h[i][j] = a_q;
      end
      if (i < N - 1) begin : g_south
        logic signed [DW-1:0] b_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)       b_q <= '0;
          else if (clear) b_q <= '0;
          else if (adv)   b_q <= b_in;
        end
        assign b_v[i][j] = b_q;
      end
    end
  end

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    beats_nxt = beats;
    dcnt_nxt  = dcnt;
    row_nxt   = bus.out_row;
    col_nxt   = bus.out_col;
    data_nxt  = bus.out_data;
    done_nxt  = 1'b0;
    clear     = 1'b0;
    adv       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          clear     = 1'b1;
          beats_nxt = bus.k_len;
          dcnt_nxt  = '0;
          state_nxt = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        dcnt_nxt = '0;
        if (bus.in_valid && bus.in_ready) begin
          adv       = 1'b1;
          beats_nxt = beats - KW'(1);
          if (beats == KW'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        adv      = 1'b1;
        dcnt_nxt = dcnt + DCW'(1);
        if (dcnt == DCW'(2 * N - 2)) begin
          state_nxt = OUT;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          if (bus.out_row == RW'(N - 1) && bus.out_col == RW'(N - 1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (bus.out_col == RW'(N - 1)) begin
            col_nxt = '0;
            row_nxt = bus.out_row + RW'(1);
          end else begin
            col_nxt = bus.out_col + RW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == OUT) data_nxt = acc[row_nxt][col_nxt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      beats         <= '0;
      dcnt          <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      bus.out_data  <= '0;
    end else begin
      state         <= state_nxt;
      beats         <= beats_nxt;
      dcnt          <= dcnt_nxt;
      bus.in_ready  <= (state_nxt == LOAD);
      bus.out_valid <= (state_nxt == OUT);
      bus.busy      <= (state_nxt != IDLE);
      bus.done      <= done_nxt;
      bus.out_row   <= row_nxt;
      bus.out_col   <= col_nxt;
      bus.out_data  <= data_nxt;
    end
  end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed, table-driven bench for systolic_array_nxn (N=4) plus an AW=32 wrap case.
module tb_systolic_array_nxn;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_array_nxn_if #(.N(4), .DW(16), .AW(40), .KW(8)) bus0 ();
  systolic_array_nxn_if #(.N(4), .DW(16), .AW(32), .KW(8)) bus1 ();

  systolic_array_nxn #(.N(4), .DW(16), .AW(40), .KW(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  systolic_array_nxn #(.N(4), .DW(16), .AW(32), .KW(8)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct packed {
    logic [7:0]              k;
    logic                    stall;
    logic                    poke;
    logic [3:0][3:0][15:0]   a;    // a[i][k]
    logic [3:0][3:0][15:0]   b;    // b[k][j]
    logic [15:0][39:0]       c;    // row-major expected results
    logic [7:0]              lat;  // first out_valid cycle after start (no stalls)
  } vec_t;

  vec_t tv [6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus0.start = 1'b0; bus0.k_len = '0; bus0.in_valid = 1'b0;
    bus0.a_col = '0; bus0.b_row = '0; bus0.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.k_len = '0; bus1.in_valid = 1'b0;
    bus1.a_col = '0; bus1.b_row = '0; bus1.out_ready = 1'b0;
  endtask

  task automatic run_job(input int n);
    vec_t v;
    int   beat, nout, first, done_c, ndone;
    bit   saw_rdy, iv, orr, poked;
    v = tv[n];
    beat = 0; nout = 0; first = -1; done_c = -1; ndone = 0;
    saw_rdy = 1'b0; poked = 1'b0;
    @(posedge clk); #1;
    bus0.start = 1'b1;
    bus0.k_len = v.k;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus0.k_len = 8'hAA;
    check($sformatf("job%0d_busy_after_start", n), 64'(bus0.busy), 64'd1);
    for (int c = 1; c < 200; c++) begin
      if (bus0.in_ready) saw_rdy = 1'b1;
      if (bus0.done) begin
        ndone++;
        if (done_c < 0) begin
          done_c = c;
          check($sformatf("job%0d_done_after_last", n), 64'(nout), 64'd16);
          check($sformatf("job%0d_done_busy", n), 64'(bus0.busy), 64'd0);
          check($sformatf("job%0d_done_out_valid", n), 64'(bus0.out_valid), 64'd0);
        end
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      iv  = (beat < int'(v.k)) && (!v.stall || ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3));
      orr = !v.stall || (c % 2 == 1);
      bus0.start     = 1'b0;
      bus0.in_valid  = iv;
      bus0.out_ready = orr;
      if (iv) begin
        for (int i = 0; i < 4; i++) begin
          bus0.a_col[i*16 +: 16] = v.a[i][beat];
          bus0.b_row[i*16 +: 16] = v.b[beat][i];
        end
      end else begin
        bus0.a_col = {$urandom(), $urandom()};
        bus0.b_row = {$urandom(), $urandom()};
      end
      if (iv && bus0.in_ready) beat++;
      if (bus0.out_valid) begin
        if (first < 0) first = c;
        if (nout < 16) begin
          check($sformatf("job%0d_data%0d", n, nout), 64'(bus0.out_data), 64'(v.c[nout]));
          check($sformatf("job%0d_row%0d", n, nout), 64'(bus0.out_row), 64'(nout / 4));
          check($sformatf("job%0d_col%0d", n, nout), 64'(bus0.out_col), 64'(nout % 4));
        end else begin
          check($sformatf("job%0d_result_count", n), 64'(nout), 64'd15);
        end
        if (v.poke && !poked) begin
          bus0.start = 1'b1;
          bus0.k_len = 8'd5;
          poked = 1'b1;
        end
        if (orr) nout++;
      end
      @(posedge clk); #1;
    end
    drive_idle();
    check($sformatf("job%0d_completed", n), 64'(done_c >= 0), 64'd1);
    check($sformatf("job%0d_done_pulses", n), 64'(ndone), 64'd1);
    check($sformatf("job%0d_results", n), 64'(nout), 64'd16);
    check($sformatf("job%0d_beats", n), 64'(beat), 64'(v.k));
    if (!v.stall) check($sformatf("job%0d_latency", n), 64'(first), 64'(v.lat));
    if (v.k == 8'd0) check($sformatf("job%0d_in_ready_seen", n), 64'(saw_rdy), 64'd0);
    if (v.poke) check($sformatf("job%0d_busy_after_poke", n), 64'(bus0.busy), 64'd0);
  endtask

  initial begin
    int nout, first, dn_c, beats;
    drive_idle();

    // Identity A against B[k][j] = 4k+j+1: C reproduces B.
    tv[0] = '0;
    tv[0].k = 8'd4; tv[0].lat = 8'd12;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tv[0].a[i][j] = (i == j) ? 16'd1 : 16'd0;
        tv[0].b[i][j] = 16'(4 * i + j + 1);
        tv[0].c[4 * i + j] = 40'(4 * i + j + 1);
      end
    tv[1] = tv[0];
    tv[1].stall = 1'b1; tv[1].lat = 8'd0;
    // All -2 times all 0x7FFF over K=3.
    tv[2] = '0;
    tv[2].k = 8'd3; tv[2].lat = 8'd11;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        tv[2].a[i][j] = 16'hFFFE;
        tv[2].b[i][j] = 16'h7FFF;
      end
    for (int m = 0; m < 16; m++) tv[2].c[m] = 40'hFF_FFFD_0006;
    // K=0: all zero, straight to drain.
    tv[3] = '0;
    tv[3].lat = 8'd8;
    // K=1 outer product a=[1..4], b=[5..8].
    tv[4] = '0;
    tv[4].k = 8'd1; tv[4].lat = 8'd9;
    tv[4].a[0][0] = 16'd1; tv[4].a[1][0] = 16'd2; tv[4].a[2][0] = 16'd3; tv[4].a[3][0] = 16'd4;
    tv[4].b[0][0] = 16'd5; tv[4].b[0][1] = 16'd6; tv[4].b[0][2] = 16'd7; tv[4].b[0][3] = 16'd8;
    tv[4].c[0]  = 40'd5;  tv[4].c[1]  = 40'd6;  tv[4].c[2]  = 40'd7;  tv[4].c[3]  = 40'd8;
    tv[4].c[4]  = 40'd10; tv[4].c[5]  = 40'd12; tv[4].c[6]  = 40'd14; tv[4].c[7]  = 40'd16;
    tv[4].c[8]  = 40'd15; tv[4].c[9]  = 40'd18; tv[4].c[10] = 40'd21; tv[4].c[11] = 40'd24;
    tv[4].c[12] = 40'd20; tv[4].c[13] = 40'd24; tv[4].c[14] = 40'd28; tv[4].c[15] = 40'd32;
    // Re-run of the identity job after an aborted one, with a start poke in OUT.
    tv[5] = tv[0];
    tv[5].poke = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus0.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_busy", 64'(bus0.busy), 64'd0);
    check("rst_done", 64'(bus0.done), 64'd0);
    check("rst_out_data", 64'(bus0.out_data), 64'd0);
    check("rst_out_row", 64'(bus0.out_row), 64'd0);
    check("rst_out_col", 64'(bus0.out_col), 64'd0);
    rst = 1'b1;

    for (int n = 0; n < 5; n++) run_job(n);

    // Abort a job in DRAIN with reset.
    @(posedge clk); #1;
    bus0.start = 1'b1;
    bus0.k_len = 8'd4;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    for (int kk = 0; kk < 4; kk++) begin
      bus0.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        bus0.a_col[i*16 +: 16] = 16'h1234;
        bus0.b_row[i*16 +: 16] = tv[0].b[kk][i];
      end
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain_busy", 64'(bus0.busy), 64'd1);
    check("drain_in_ready", 64'(bus0.in_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 64'(bus0.busy), 64'd0);
    check("abort_out_valid", 64'(bus0.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus0.in_ready), 64'd0);
    check("abort_out_data", 64'(bus0.out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus0.done || bus0.busy || bus0.out_valid) begin
        check("abort_quiet", 64'({bus0.done, bus0.busy, bus0.out_valid}), 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    run_job(5);

    // AW=32 wrap: 255 * (0x8000 * 0x8000) mod 2^32.
    nout = 0; first = -1; dn_c = -1; beats = 0;
    @(posedge clk); #1;
    bus1.start = 1'b1;
    bus1.k_len = 8'd255;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int c = 1; c < 600; c++) begin
      if (bus1.done && dn_c < 0) dn_c = c;
      if (dn_c >= 0) break;
      bus1.in_valid  = (beats < 255);
      bus1.a_col     = {4{16'h8000}};
      bus1.b_row     = {4{16'h8000}};
      bus1.out_ready = 1'b1;
      if (bus1.in_valid && bus1.in_ready) beats++;
      if (bus1.out_valid) begin
        if (first < 0) first = c;
        if (nout < 16) begin
          check($sformatf("wrap_data%0d", nout), 64'(bus1.out_data), 64'h0000_0000_C000_0000);
          check($sformatf("wrap_row%0d", nout), 64'(bus1.out_row), 64'(nout / 4));
          check($sformatf("wrap_col%0d", nout), 64'(bus1.out_col), 64'(nout % 4));
        end
        nout++;
      end
      @(posedge clk); #1;
    end
    drive_idle();
    check("wrap_completed", 64'(dn_c >= 0), 64'd1);
    check("wrap_results", 64'(nout), 64'd16);
    check("wrap_latency", 64'(first), 64'd263);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
